btn_hold_reader: RTL and testbench

Input-side counterpart to the "PRESS / HOLD" game screens. It samples the raw centre pushbutton, synchronises and debounces it, and classifies each actuation as a short press or a long hold. It also drives a 0..96 progress value that the screen renderers use directly as a bar width in OLED x-coordinates (96-pixel-wide panel). It sits between the board button pin and the game-state controller, one instance per prompted button.

---
 rtl/btn_hold_reader.sv | 156 +++++++++++++++
 tb/tb_btn_hold_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_hold_reader.sv
// Centre-button reader: sync, debounce, press/hold classify.
// Drives a 0..96 progress value used as a bar width in pixels.
module btn_hold_reader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       enable,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       hold_pulse,
  output logic       hold_active,
  output logic [6:0] hold_progress
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST =
    SW'(STEP_CYCLES - 1);
  localparam logic [6:0] PROG_MAX  = 7'd96;
  localparam logic [6:0] PROG_LAST = 7'd95;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } state_e;

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_prev_q;
  logic [DW-1:0] db_cnt_q;

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [6:0]    prog_q, prog_d;
  logic          press_q, press_d;
  logic          hold_q, hold_d;

  logic          db_rise;

  // Two-flop synchroniser on the asynchronous button pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: level follows sync only after a full stable run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else if (sync2_q == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_q     <= sync2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign db_rise = db_q & ~db_prev_q;

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev_q <= 1'b0;
      state_q   <= IDLE;
      step_q    <= '0;
      prog_q    <= '0;
      press_q   <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      db_prev_q <= db_q;
      state_q   <= state_d;
      step_q    <= step_d;
      prog_q    <= prog_d;
      press_q   <= press_d;
      hold_q    <= hold_d;
    end
  end

  // Next state; a low enable overrides every transition.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    prog_d  = prog_q;
    press_d = 1'b0;
    hold_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      step_d  = '0;
      prog_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (db_rise) begin
            state_d = DOWN;
            step_d  = '0;
            prog_d  = '0;
          end
        end
        DOWN: begin
          if (!db_q) begin
            state_d = IDLE;
            press_d = 1'b1;
            prog_d  = '0;
          end else if (step_q == STEP_LAST) begin
            step_d = '0;
            prog_d = prog_q + 7'd1;
            if (prog_q == PROG_LAST) begin
              state_d = HELD;
              hold_d  = 1'b1;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        HELD: begin
          if (!db_q) begin
            state_d = IDLE;
            prog_d  = '0;
          end else begin
            prog_d = PROG_MAX;
          end
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
          prog_d  = '0;
        end
      endcase
    end
  end

  assign btn_level     = db_q;
  assign press_pulse   = press_q;
  assign hold_pulse    = hold_q;
  assign hold_active   = (state_q == HELD);
  assign hold_progress = prog_q;

endmodule

// File: tb/tb_btn_hold_reader.sv
// Bench for btn_hold_reader: directed cases plus random
// presses, compared each cycle against a behavioural model.
module tb_btn_hold_reader;

  localparam int DEB  = 4;
  localparam int STEP = 2;
  localparam int HOLD = 96 * STEP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       enable = 1'b0;
  logic       btn_level;
  logic       press_pulse;
  logic       hold_pulse;
  logic       hold_active;
  logic [6:0] hold_progress;

  btn_hold_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .enable(enable),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .hold_pulse(hold_pulse),
    .hold_active(hold_active),
    .hold_progress(hold_progress)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name,
                     input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  // Behavioural model: mode 0 idle, 1 pressing, 2 held.
  bit m_s1, m_s2, m_level, m_prev;
  bit m_hist[DEB];
  int m_mode, m_age;
  bit m_press, m_hold;

  function automatic int m_prog();
    if (m_mode == 1) return m_age / STEP;
    if (m_mode == 2) return 96;
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_prev = 0;
    for (int i = 0; i < DEB; i++) m_hist[i] = 0;
    m_mode = 0; m_age = 0; m_press = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit raw, input bit en);
    bit all_diff;
    m_press = 0;
    m_hold  = 0;
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (m_level && !m_prev) begin
        m_mode = 1;
        m_age  = 0;
      end
    end else if (m_mode == 1) begin
      if (!m_level) begin
        m_mode  = 0;
        m_press = 1;
      end else begin
        m_age++;
        if (m_age == HOLD) begin
          m_mode = 2;
          m_hold = 1;
        end
      end
    end else begin
      if (!m_level) m_mode = 0;
    end
    for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_s2;
    all_diff = 1;
    for (int i = 0; i < DEB; i++)
      if (m_hist[i] == m_level) all_diff = 0;
    m_prev = m_level;
    if (all_diff) m_level = !m_level;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // Cycle bookkeeping from observed DUT outputs.
  int cyc = 0;
  int press_cnt = 0;
  int hold_cnt = 0;
  int pk = 0;
  int lvl_rise_cyc = -1;
  int hold_cyc = -1;
  int hp_prog = 0;
  int hp_act = 0;
  bit lvl_seen = 0;
  bit lvl_prev = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      cyc++;
      model_step(btn_raw, enable);
    end
    #1;
    chk("btn_level", int'(btn_level), int'(m_level));
    chk("press_pulse", int'(press_pulse), int'(m_press));
    chk("hold_pulse", int'(hold_pulse), int'(m_hold));
    chk("hold_active", int'(hold_active),
        int'(m_mode == 2));
    chk("hold_progress", int'(hold_progress), m_prog());
    if (press_pulse && hold_pulse)
      chk("pulse_overlap", 1, 0);
    if (press_pulse) press_cnt++;
    if (hold_pulse) begin
      hold_cnt++;
      hold_cyc = cyc;
      hp_prog  = int'(hold_progress);
      hp_act   = int'(hold_active);
    end
    if (int'(hold_progress) > pk) pk = int'(hold_progress);
    if (btn_level && !lvl_prev) begin
      lvl_rise_cyc = cyc;
      lvl_seen = 1;
    end
    lvl_prev = btn_level;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    press_cnt = 0; hold_cnt = 0; pk = 0;
    lvl_seen = 0; lvl_rise_cyc = -1; hold_cyc = -1;
  endtask

  task automatic wait_level(input string name);
    int n;
    n = 0;
    while (!lvl_seen && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!lvl_seen) chk({name, "_timeout"}, 0, 1);
  endtask

  int e0;
  int n;

  initial begin
    model_reset();
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    // Reset mid-hold: outputs drop at once.
    enable = 1'b1;
    btn_raw = 1'b1;
    n = 0;
    while (hold_progress < 7'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midhold_reached", int'(hold_progress >= 7'd10), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(press_pulse), 0);
    chk("rst_hold", int'(hold_pulse), 0);
    chk("rst_active", int'(hold_active), 0);
    chk("rst_prog", int'(hold_progress), 0);
    btn_raw = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(10);

    // Three-cycle glitch is filtered.
    clear_obs();
    btn_raw = 1'b1;
    cycles(3);
    btn_raw = 1'b0;
    cycles(12);
    chk("glitch_level", int'(lvl_seen), 0);
    chk("glitch_press", press_cnt, 0);
    chk("glitch_hold", hold_cnt, 0);

    // Short press of 40 raw cycles.
    clear_obs();
    btn_raw = 1'b1;
    e0 = cyc + 1;
    cycles(40);
    btn_raw = 1'b0;
    cycles(20);
    chk("short_lvl_lat", lvl_rise_cyc - e0, 1 + DEB);
    chk("short_press", press_cnt, 1);
    chk("short_hold", hold_cnt, 0);
    chk("short_peak_ok", int'(pk >= 17 && pk <= 19), 1);

    // Long hold reaches threshold.
    clear_obs();
    btn_raw = 1'b1;
    n = 0;
    while (hold_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("long_hold_cnt", hold_cnt, 1);
    chk("long_hold_lat", hold_cyc - lvl_rise_cyc, 1 + HOLD);
    chk("long_hold_prog", hp_prog, 96);
    chk("long_hold_act", hp_act, 1);
    cycles(5);
    btn_raw = 1'b0;
    cycles(15);
    chk("long_rel_prog", int'(hold_progress), 0);
    chk("long_rel_press", press_cnt, 0);

    // Release lands on the step that would reach 96.
    clear_obs();
    btn_raw = 1'b1;
    wait_level("race");
    while (cyc + 1 < lvl_rise_cyc + HOLD - DEB - 1)
      @(negedge clk);
    btn_raw = 1'b0;
    cycles(20);
    chk("race_press", press_cnt, 1);
    chk("race_hold", hold_cnt, 0);
    chk("race_peak", pk, 95);

    // Enable gating: pressed before enable rises.
    clear_obs();
    enable = 1'b0;
    btn_raw = 1'b1;
    cycles(15);
    enable = 1'b1;
    cycles(15);
    chk("gate_prog", int'(hold_progress), 0);
    chk("gate_press", press_cnt + hold_cnt, 0);
    btn_raw = 1'b0;
    cycles(15);
    chk("gate_rel_press", press_cnt, 0);
    btn_raw = 1'b1;
    cycles(15);
    btn_raw = 1'b0;
    cycles(15);
    chk("gate_again_press", press_cnt, 1);

    // Abort: drop enable at progress 50.
    clear_obs();
    btn_raw = 1'b1;
    n = 0;
    while (hold_progress != 7'd50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached", int'(hold_progress), 50);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_prog", int'(hold_progress), 0);
    chk("abort_active", int'(hold_active), 0);
    enable = 1'b1;
    cycles(10);
    btn_raw = 1'b0;
    cycles(15);
    chk("abort_pulses", press_cnt + hold_cnt, 0);

    // Random presses, glitches and enable toggles.
    for (int i = 0; i < 60; i++) begin
      btn_raw = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0: cycles($urandom_range(1, 4));
        1: cycles($urandom_range(5, 40));
        2: cycles($urandom_range(40, 120));
        default: cycles($urandom_range(180, 230));
      endcase
    end
    btn_raw = 1'b0;
    cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
